reg_status_file: RTL

//   Architectural register file with per-register rename tags; consumes the ROB commit port.

---
 rtl/reg_status_file.sv | 100 ++++++++++
 1 files changed

// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename tags, updated by decoder dispatch and ROB commit.
// Optional macro COMMIT_BYPASS_EN forwards a clearing commit to same-cycle reads.
module reg_status_file #(
  parameter int                DATA_W   = 32,
  parameter int                REG_W    = 5,
  parameter int                TAG_W    = 4,
  parameter logic [TAG_W-1:0]  TAG_FREE = 4'b1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [REG_W-1:0]  rs1_addr,
  input  logic [REG_W-1:0]  rs2_addr,
  output logic [TAG_W-1:0]  rs1_tag,
  output logic [DATA_W-1:0] rs1_data,
  output logic [TAG_W-1:0]  rs2_tag,
  output logic [DATA_W-1:0] rs2_data,
  input  logic              alloc_en,
  input  logic [REG_W-1:0]  alloc_addr,
  input  logic [TAG_W-1:0]  alloc_tag,
  input  logic              com_en,
  input  logic [REG_W-1:0]  com_addr,
  input  logic [DATA_W-1:0] com_data,
  input  logic [TAG_W-1:0]  com_tag
);

  localparam int NREGS = 2**REG_W;

  logic [DATA_W-1:0] data_q [NREGS];
  logic [DATA_W-1:0] data_d [NREGS];
  logic [TAG_W-1:0]  tag_q  [NREGS];
  logic [TAG_W-1:0]  tag_d  [NREGS];

  logic com_fire;
  logic com_clears;
  logic alloc_fire;

  assign com_fire   = rdy && com_en && (com_addr != '0);
  assign com_clears = (tag_q[com_addr] == com_tag);
  // A free tag on the alloc port carries no producer, so it is dropped.
  assign alloc_fire = rdy && alloc_en && (alloc_addr != '0) && (alloc_tag != TAG_FREE);

  // Alloc is applied after commit so a same-register rename keeps its new tag.
  always_comb begin
    data_d = data_q;
    tag_d  = tag_q;
    if (com_fire) begin
      data_d[com_addr] = com_data;
      if (com_clears) begin
        tag_d[com_addr] = TAG_FREE;
      end
    end
    if (alloc_fire) begin
      tag_d[alloc_addr] = alloc_tag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= TAG_FREE;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        data_q[i] <= data_d[i];
        tag_q[i]  <= tag_d[i];
      end
    end
  end

  always_comb begin
    rs1_data = data_q[rs1_addr];
    rs1_tag  = tag_q[rs1_addr];
    rs2_data = data_q[rs2_addr];
    rs2_tag  = tag_q[rs2_addr];
`ifdef COMMIT_BYPASS_EN
    if (rst && com_fire && com_clears) begin
      if (rs1_addr == com_addr) begin
        rs1_data = com_data;
        rs1_tag  = TAG_FREE;
      end
      if (rs2_addr == com_addr) begin
        rs2_data = com_data;
        rs2_tag  = TAG_FREE;
      end
    end
`endif
    // x0 is hard-wired regardless of stored contents or bypass.
    if (rs1_addr == '0) begin
      rs1_data = '0;
      rs1_tag  = TAG_FREE;
    end
    if (rs2_addr == '0) begin
      rs2_data = '0;
      rs2_tag  = TAG_FREE;
    end
  end

endmodule
